// File: rtl/i2c_slave_controller.sv
// i2c_slave_controller
// Sequencing FSM for the I2C slave datapath. Bus events from the decoder and
// bit-timing pulses from the SCL timer move the state machine. Every output is
// a registered decode of the state register, so each output lags its state
// by one cycle. byte_count is the exception: it updates on the same edge as
// the transition that completes a data byte.
module i2c_slave_controller #(
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_found,
    input  logic                   stop_found,
    input  logic                   address_match,
    input  logic                   rw_mode,
    input  logic                   byte_received,
    input  logic                   ack_prep,
    input  logic                   check_ack,
    input  logic                   ack_done,
    input  logic                   sda_in,
    input  logic                   tx_fifo_empty,
    input  logic                   rx_fifo_full,
    output logic                   rx_enable,
    output logic                   tx_enable,
    output logic [1:0]             sda_mode,
    output logic                   load_data,
    output logic                   tx_pop,
    output logic                   rx_push,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] byte_count
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR_RX,
        ADDR_CHECK,
        ACK_WAIT,
        ACK_DRIVE,
        NACK_WAIT,
        NACK_DRIVE,
        DATA_RX,
        RX_STORE,
        RX_ACK_WAIT,
        RX_ACK_DRIVE,
        LOAD,
        DATA_TX,
        MACK_WAIT,
        MACK_END
    } state_t;

    // SDA output encodings
    localparam logic [1:0] SDA_RELEASE = 2'b00;
    localparam logic [1:0] SDA_ACK     = 2'b01;
    localparam logic [1:0] SDA_NACK    = 2'b10;
    localparam logic [1:0] SDA_TX      = 2'b11;

    state_t state_reg;
    logic   rw_reg;     // R/W bit of the address byte
    logic   full_reg;   // RX FIFO was full when the current byte was stored
    logic   mack_reg;   // master's ACK bit (1 = NACK, stop transmitting)

    // Single-process FSM: output decode of the current state, latched flags,
    // byte counter and next-state selection with stop > start > local priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            rw_reg     <= 1'b0;
            full_reg   <= 1'b0;
            mack_reg   <= 1'b0;
            rx_enable  <= 1'b0;
            tx_enable  <= 1'b0;
            sda_mode   <= SDA_RELEASE;
            load_data  <= 1'b0;
            tx_pop     <= 1'b0;
            rx_push    <= 1'b0;
            busy       <= 1'b0;
            byte_count <= '0;
        end else begin
            // Registered Moore outputs: reflect the state held during this cycle.
            rx_enable <= (state_reg == ADDR_RX) || (state_reg == DATA_RX);
            tx_enable <= (state_reg == DATA_TX);
            load_data <= (state_reg == LOAD);
            tx_pop    <= (state_reg == LOAD) && !tx_fifo_empty;
            rx_push   <= (state_reg == RX_STORE) && !rx_fifo_full;
            busy      <= (state_reg != IDLE);
            case (state_reg)
                ACK_DRIVE:    sda_mode <= SDA_ACK;
                NACK_DRIVE:   sda_mode <= SDA_NACK;
                RX_ACK_DRIVE: sda_mode <= full_reg ? SDA_NACK : SDA_ACK;
                DATA_TX:      sda_mode <= SDA_TX;
                default:      sda_mode <= SDA_RELEASE;
            endcase

            if (stop_found) begin
                state_reg <= IDLE;
            end else if (start_found) begin
                // A (repeated) start abandons whatever was in progress.
                state_reg  <= ADDR_RX;
                byte_count <= '0;
            end else begin
                case (state_reg)
                    ADDR_RX:
                        if (byte_received) state_reg <= ADDR_CHECK;
                    ADDR_CHECK: begin
                        rw_reg    <= rw_mode;
                        state_reg <= address_match ? ACK_WAIT : NACK_WAIT;
                    end
                    ACK_WAIT:
                        if (ack_prep) state_reg <= ACK_DRIVE;
                    ACK_DRIVE:
                        if (ack_done) state_reg <= rw_reg ? LOAD : DATA_RX;
                    NACK_WAIT:
                        if (ack_prep) state_reg <= NACK_DRIVE;
                    NACK_DRIVE:
                        if (ack_done) state_reg <= IDLE;
                    DATA_RX:
                        if (byte_received) state_reg <= RX_STORE;
                    RX_STORE: begin
                        full_reg   <= rx_fifo_full;
                        byte_count <= byte_count + 1'b1;
                        state_reg  <= RX_ACK_WAIT;
                    end
                    RX_ACK_WAIT:
                        if (ack_prep) state_reg <= RX_ACK_DRIVE;
                    RX_ACK_DRIVE:
                        if (ack_done) state_reg <= full_reg ? IDLE : DATA_RX;
                    LOAD:
                        state_reg <= DATA_TX;
                    DATA_TX:
                        if (ack_prep) begin
                            byte_count <= byte_count + 1'b1;
                            state_reg  <= MACK_WAIT;
                        end
                    MACK_WAIT:
                        if (check_ack) begin
                            mack_reg  <= sda_in;
                            state_reg <= MACK_END;
                        end
                    MACK_END:
                        if (ack_done) state_reg <= mack_reg ? IDLE : LOAD;
                    default:
                        state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_controller.sv
// Directed testbench for i2c_slave_controller. Each bus event is applied as a
// one-cycle pulse followed by one settling cycle, so after ev() returns the
// outputs show the decode of the state entered by that event.
module tb_i2c_slave_controller;

    logic       clk = 1'b0;
    logic       rst, start_found, stop_found, address_match, rw_mode;
    logic       byte_received, ack_prep, check_ack, ack_done, sda_in;
    logic       tx_fifo_empty, rx_fifo_full;
    logic       rx_enable, tx_enable, load_data, tx_pop, rx_push, busy;
    logic [1:0] sda_mode;
    logic [7:0] byte_count;

    int errors = 0;
    int checks = 0;
    int push_cnt = 0;
    int pop_cnt = 0;
    int load_cnt = 0;

    localparam int EV_START = 0, EV_STOP = 1, EV_BYTE = 2, EV_PREP = 3;
    localparam int EV_CHECK = 4, EV_DONE = 5, EV_BOTH = 6;

    i2c_slave_controller #(.COUNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start_found(start_found), .stop_found(stop_found),
        .address_match(address_match), .rw_mode(rw_mode),
        .byte_received(byte_received), .ack_prep(ack_prep), .check_ack(check_ack),
        .ack_done(ack_done), .sda_in(sda_in), .tx_fifo_empty(tx_fifo_empty),
        .rx_fifo_full(rx_fifo_full), .rx_enable(rx_enable), .tx_enable(tx_enable),
        .sda_mode(sda_mode), .load_data(load_data), .tx_pop(tx_pop),
        .rx_push(rx_push), .busy(busy), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    // Count high cycles of the one-shot outputs, sampled mid-cycle.
    always @(negedge clk) begin
        if (rx_push === 1'b1) push_cnt++;
        if (tx_pop === 1'b1) pop_cnt++;
        if (load_data === 1'b1) load_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ev(input int which);
        case (which)
            EV_START: start_found = 1'b1;
            EV_STOP:  stop_found = 1'b1;
            EV_BYTE:  byte_received = 1'b1;
            EV_PREP:  ack_prep = 1'b1;
            EV_CHECK: check_ack = 1'b1;
            EV_DONE:  ack_done = 1'b1;
            default: begin start_found = 1'b1; stop_found = 1'b1; end
        endcase
        tick();
        start_found = 1'b0; stop_found = 1'b0; byte_received = 1'b0;
        ack_prep = 1'b0; check_ack = 1'b0; ack_done = 1'b0;
        tick();
    endtask

    function automatic logic [7:0] all_outs();
        return {rx_enable, tx_enable, sda_mode, load_data, tx_pop, rx_push, busy};
    endfunction

    // Start + address byte + address ACK phase for a matching address.
    task automatic addr_phase(input logic rw);
        rw_mode = rw;
        address_match = 1'b1;
        ev(EV_START);
        ev(EV_BYTE);
        ev(EV_PREP);
        check("addr_ack_drive", sda_mode, 2'b01);
        ev(EV_DONE);
    endtask

    initial begin
        rst = 1'b1; start_found = 0; stop_found = 0; address_match = 0; rw_mode = 0;
        byte_received = 0; ack_prep = 0; check_ack = 0; ack_done = 0; sda_in = 1;
        tx_fifo_empty = 0; rx_fifo_full = 0;
        tick(); tick();
        check("reset_outs", all_outs(), 8'h00);
        check("reset_count", byte_count, 8'd0);
        rst = 1'b0;
        tick();
        check("idle_outs", all_outs(), 8'h00);

        // Address mismatch: NACK then IDLE, no push.
        push_cnt = 0;
        address_match = 1'b0;
        ev(EV_START);
        check("nack_addr_rx", {rx_enable, busy}, 2'b11);
        ev(EV_BYTE);
        check("nack_wait_release", sda_mode, 2'b00);
        ev(EV_PREP);
        check("nack_drive", sda_mode, 2'b10);
        ev(EV_DONE);
        check("nack_idle", busy, 1'b0);
        check("nack_no_push", push_cnt, 0);
        $display("txn: address mismatch done, byte_count=%0d", byte_count);

        // Master write of 3 bytes.
        push_cnt = 0;
        addr_phase(1'b0);
        check("w_rx_enable", rx_enable, 1'b1);
        for (int i = 0; i < 3; i++) begin
            ev(EV_BYTE);
            check("w_push", rx_push, 1'b1);
            check("w_count", byte_count, i + 1);
            ev(EV_PREP);
            check("w_ack", sda_mode, 2'b01);
            ev(EV_DONE);
        end
        check("w_push_cnt", push_cnt, 3);
        ev(EV_STOP);
        check("w_stop_busy", busy, 1'b0);
        check("w_stop_count", byte_count, 8'd3);
        $display("txn: write 3 bytes done, pushes=%0d", push_cnt);

        // Write with RX FIFO full on the second byte.
        push_cnt = 0;
        addr_phase(1'b0);
        check("f_count_clear", byte_count, 8'd0);
        ev(EV_BYTE); ev(EV_PREP); ev(EV_DONE);
        rx_fifo_full = 1'b1;
        ev(EV_BYTE);
        check("f_no_push", rx_push, 1'b0);
        check("f_count", byte_count, 8'd2);
        ev(EV_PREP);
        check("f_nack", sda_mode, 2'b10);
        ev(EV_DONE);
        check("f_idle", busy, 1'b0);
        check("f_push_cnt", push_cnt, 1);
        rx_fifo_full = 1'b0;
        $display("txn: write with full fifo done, pushes=%0d", push_cnt);

        // Master read of 2 bytes: ACK on the first, NACK on the second.
        pop_cnt = 0; load_cnt = 0;
        addr_phase(1'b1);
        check("r_load1", {load_data, tx_pop}, 2'b11);
        tick();
        check("r_tx1", {tx_enable, sda_mode}, 3'b111);
        ev(EV_PREP);
        check("r_count1", byte_count, 8'd1);
        check("r_mack_release", sda_mode, 2'b00);
        sda_in = 1'b0;
        ev(EV_CHECK);
        sda_in = 1'b1;
        ev(EV_DONE);
        check("r_load2", {load_data, tx_pop}, 2'b11);
        tick();
        check("r_tx2", {tx_enable, sda_mode}, 3'b111);
        ev(EV_PREP);
        sda_in = 1'b1;
        ev(EV_CHECK);
        sda_in = 1'b0;
        ev(EV_DONE);
        check("r_idle", busy, 1'b0);
        check("r_count2", byte_count, 8'd2);
        check("r_load_cnt", load_cnt, 2);
        check("r_pop_cnt", pop_cnt, 2);
        sda_in = 1'b1;
        $display("txn: read 2 bytes done, pops=%0d", pop_cnt);

        // Repeated start mid-DATA_RX, then simultaneous start+stop.
        addr_phase(1'b0);
        ev(EV_BYTE); ev(EV_PREP); ev(EV_DONE);
        check("rs_count_before", byte_count, 8'd1);
        ev(EV_START);
        check("rs_count_clear", byte_count, 8'd0);
        check("rs_addr_rx", {rx_enable, busy}, 2'b11);
        ev(EV_BOTH);
        check("both_idle", busy, 1'b0);
        $display("txn: repeated start and start+stop done");

        // Reset mid-transaction.
        addr_phase(1'b0);
        ev(EV_BYTE);
        rst = 1'b1;
        tick();
        check("rst_mid_outs", all_outs(), 8'h00);
        check("rst_mid_count", byte_count, 8'd0);
        tick();
        rst = 1'b0;
        tick();
        check("rst_mid_idle", all_outs(), 8'h00);
        $display("txn: reset mid-transaction done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
